request_unit: RTL
=================

REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 SHALL have port: CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: RST  in  1  reset; synchronous, active-high; one clock; no other clock or reset.
REQ-003 SHALL have port: iREN  in  1  instruction-fetch enable from the control unit.
REQ-004 SHALL have port: dREN  in  1  data-read request from the control unit, for the current instruction.
REQ-005 SHALL have port: dWEN  in  1  data-write request from the control unit, for the current instruction.
REQ-006 SHALL have port: halt  in  1  halt decoded by the control unit.
REQ-007 SHALL have port: ihit  in  1  instruction-memory access complete.
REQ-008 SHALL have port: dhit  in  1  data-memory access complete.
REQ-009 SHALL have port: imemREN  out  1  instruction-memory read request.
REQ-010 SHALL have port: dmemREN  out  1  data-memory read request.
REQ-011 SHALL have port: dmemWEN  out  1  data-memory write request.
REQ-012 SHALL have port: pc_en  out  1  one-cycle PC-advance strobe.
REQ-013 SHALL have port: halt_out  out  1  sticky processor-halted flag.
REQ-014 SHALL have port: stall_cnt  out  16  count of cycles spent waiting on memory.

Function
REQ-015 SHALL implement FSM states FETCH, DATA, HALTED, encoded as reqstate_t.
REQ-016 FETCH: imemREN = iREN; dmemREN = dmemWEN = 0.
REQ-017 FETCH with ihit=1, halt=1 -> HALTED next cycle; pc_en=0; halt takes priority over dREN/dWEN.
REQ-018 FETCH with ihit=1, halt=0, dREN=dWEN=0 -> stay in FETCH; pc_en=1 in the same cycle.
REQ-019 FETCH with ihit=1, halt=0, dREN|dWEN=1 -> DATA next cycle; pc_en=0; the request type is registered that cycle.
REQ-020 DATA: imemREN=0; registered dmemREN/dmemWEN held constant until dhit, so data-request latency is one cycle after ihit.
REQ-021 DATA with dhit=1 -> FETCH next cycle; pc_en=1 in the dhit cycle; dmemREN/dmemWEN drop to 0 the next cycle.
REQ-022 dREN=dWEN=1 together at capture -> write wins: dmemWEN=1, dmemREN=0.
REQ-023 dhit while in FETCH SHALL be ignored; ihit while in DATA SHALL be ignored.
REQ-024 pc_en SHALL never exceed one cycle per completed instruction and SHALL never assert in HALTED.
REQ-025 HALTED: imemREN=dmemREN=dmemWEN=pc_en=0, halt_out=1; exit only by RST.
REQ-026 stall_cnt increments by 1 for each cycle that meets either condition: (FETCH, imemREN=1, ihit=0) or (DATA, dhit=0).
REQ-027 stall_cnt saturates at 16'hFFFF; it does not wrap.
REQ-028 stall_cnt holds its value in HALTED.
REQ-029 iREN=0 in FETCH -> no request issued, no stall counted, state held.

Reset
REQ-030 RST=1 at a clock edge SHALL force state=FETCH, registered dmemREN/dmemWEN=0, halt_out=0, stall_cnt=0.
REQ-031 RST SHALL take priority over ihit, dhit and halt in the same cycle.
REQ-032 RST mid-DATA SHALL drop the pending data request with no pc_en.

Structure
REQ-033 reqstate_t (FETCH, DATA, HALTED) SHALL live in cpu_types_pkg.
REQ-034 Ports SHALL be grouped in interface request_unit_if, with modport req, in include/request_unit_if.vh.
REQ-035 Single flat module; no sub-module needed.

Verification
REQ-036 R-type: iREN=1; ihit=1 for 1 cycle with dREN=dWEN=0 -> pc_en=1 that cycle; state stays FETCH; stall_cnt=0.
REQ-037 lw: ihit=1 with dREN=1 -> next cycle dmemREN=1, imemREN=0; dhit after 3 wait cycles -> pc_en=1 in dhit cycle; stall_cnt=3.
REQ-038 sw and dual request: ihit with dREN=dWEN=1 -> next cycle dmemWEN=1, dmemREN=0.
REQ-039 halt: ihit=1, halt=1, dREN=1 -> next cycle halt_out=1, all requests 0; further ihit/dhit pulses give pc_en=0.
REQ-040 Saturation: hold ihit=0 for 70000 cycles -> stall_cnt=16'hFFFF and stays there.
REQ-041 Reset mid-DATA: assert RST while dmemREN=1 -> next cycle dmemREN=0, stall_cnt=0, halt_out=0, state FETCH; no pc_en pulse.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared CPU type definitions.
//   reqstate_t : request unit states (FETCH, DATA, HALTED)
//   STALL_MAX  : saturation value of the memory-stall counter
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/request_unit_if.sv
// request_unit_if
// Groups the request unit signals. The req modport is the request unit's view:
//   inputs  : CLK, RST, iREN, dREN, dWEN, halt, ihit, dhit
//   outputs : imemREN, dmemREN, dmemWEN, pc_en, halt_out, stall_cnt[15:0]
interface request_unit_if;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic        dREN;
  logic        dWEN;
  logic        halt;
  logic        ihit;
  logic        dhit;
  logic        imemREN;
  logic        dmemREN;
  logic        dmemWEN;
  logic        pc_en;
  logic        halt_out;
  logic [15:0] stall_cnt;

  modport req (
    input  CLK, RST, iREN, dREN, dWEN, halt, ihit, dhit,
    output imemREN, dmemREN, dmemWEN, pc_en, halt_out, stall_cnt
  );

endinterface

// File: rtl/request_unit.sv
// request_unit
// Sequences instruction fetch and data access requests to memory, produces the
// PC-advance strobe, latches halt, and counts cycles spent waiting on memory.
// Ports:
//   CLK, RST (sync, active-high)         : clock and reset
//   iREN, dREN, dWEN, halt               : control-unit requests for the current instruction
//   ihit, dhit                           : instruction / data memory access complete
//   imemREN, dmemREN, dmemWEN            : memory request outputs
//   pc_en                                : one-cycle PC-advance strobe
//   halt_out                             : sticky halted flag
//   stall_cnt[15:0]                      : saturating count of memory-wait cycles
module request_unit
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        halt,
  input  logic        ihit,
  input  logic        dhit,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        pc_en,
  output logic        halt_out,
  output logic [15:0] stall_cnt
);

  reqstate_t   state_r;
  reqstate_t   next_state_s;
  logic        dmem_ren_r;
  logic        dmem_wen_r;
  logic [15:0] stall_cnt_r;
  logic        imem_ren_s;
  logic        pc_en_s;
  logic        capture_s;
  logic        stall_s;

  // Next-state and combinational strobes for the request sequencer.
  always_comb begin
    next_state_s = state_r;
    imem_ren_s   = 1'b0;
    pc_en_s      = 1'b0;
    capture_s    = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      FETCH: begin
        imem_ren_s = iREN;
        if (iREN && ihit) begin
          // halt outranks any data request of the halting instruction
          if (halt) begin
            next_state_s = HALTED;
          end else if (dREN || dWEN) begin
            next_state_s = DATA;
            capture_s    = 1'b1;
          end else begin
            pc_en_s = 1'b1;
          end
        end else if (iREN) begin
          stall_s = 1'b1;
        end else begin
          next_state_s = FETCH;
        end
      end
      DATA: begin
        if (dhit) begin
          next_state_s = FETCH;
          pc_en_s      = 1'b1;
        end else begin
          stall_s = 1'b1;
        end
      end
      HALTED: begin
        next_state_s = HALTED;
      end
      default: begin
        next_state_s = FETCH;
      end
    endcase
  end

  // State, registered data request and stall counter; reset outranks every hit/halt.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= FETCH;
      dmem_ren_r  <= 1'b0;
      dmem_wen_r  <= 1'b0;
      stall_cnt_r <= 16'd0;
    end else begin
      state_r <= next_state_s;
      if (capture_s) begin
        // a simultaneous read and write request resolves to a write
        dmem_wen_r <= dWEN;
        dmem_ren_r <= dREN & ~dWEN;
      end else if ((state_r == DATA) && dhit) begin
        dmem_wen_r <= 1'b0;
        dmem_ren_r <= 1'b0;
      end else begin
        dmem_wen_r <= dmem_wen_r;
        dmem_ren_r <= dmem_ren_r;
      end
      if (stall_s && (stall_cnt_r != STALL_MAX)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  // The reset cycle must not advance the PC even when a hit arrives with it.
  assign pc_en     = pc_en_s & ~RST;
  assign imemREN   = imem_ren_s;
  assign dmemREN   = dmem_ren_r;
  assign dmemWEN   = dmem_wen_r;
  assign halt_out  = (state_r == HALTED);
  assign stall_cnt = stall_cnt_r;

endmodule
